// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: arbitrates handshake and data-packet requests for usb_transmitter,
// fetches payload bytes one at a time, enforces the inter-packet gap and times out stalls.
module usb_tx_scheduler #(
    parameter int unsigned IPG_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 4095,
    parameter int unsigned MAX_LEN    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [1:0] hs_pid,
    output logic       hs_grant,
    input  logic       data_req,
    input  logic [6:0] data_len,
    output logic       data_grant,
    output logic       buf_rd,
    input  logic [7:0] buf_data,
    output logic       tx_ena,
    output logic [1:0] pid,
    output logic       ack_prep,
    output logic [7:0] parallel_in,
    input  logic       tx_load,
    input  logic       ack_done,
    input  logic       tx_complete,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic       err_req
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HS_WAIT,
        S_DATA_FETCH,
        S_DATA_RUN,
        S_DATA_WAIT,
        S_GAP
    } state_t;

    localparam int unsigned GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [1:0]       LP_PID_DATA = 2'b11;
    localparam logic [6:0]       LP_MAX_LEN  = 7'(MAX_LEN);
    localparam logic [11:0]      LP_TO_LAST  = 12'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] LP_GAP_LAST = GAP_W'(IPG_CYCLES - 1);

    state_t           r_state;
    logic [6:0]       r_remaining;
    logic [11:0]      r_to_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_hs_grant, r_data_grant, r_buf_rd, r_ack_prep, r_tx_ena;
    logic             r_busy, r_done, r_err_timeout, r_err_req;
    logic [1:0]       r_pid;
    logic [7:0]       r_parallel_in;

    state_t           w_state_nxt;
    logic             w_timeout;
    logic             w_hs_legal, w_len_legal, w_to_last;
    logic [6:0]       w_remaining;
    logic [11:0]      w_to_cnt;
    logic [GAP_W-1:0] w_gap_cnt;
    logic             w_hs_grant, w_data_grant, w_buf_rd, w_ack_prep, w_tx_ena;
    logic             w_busy, w_done, w_err_req;
    logic [1:0]       w_pid;
    logic [7:0]       w_parallel_in;

    assign w_hs_legal  = (hs_pid != 2'b11);
    assign w_len_legal = (data_len != 7'd0) && (data_len <= LP_MAX_LEN);
    assign w_to_last   = (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_hs_grant    <= 1'b0;
            r_data_grant  <= 1'b0;
            r_buf_rd      <= 1'b0;
            r_ack_prep    <= 1'b0;
            r_tx_ena      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_req     <= 1'b0;
            r_pid         <= '0;
            r_parallel_in <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining;
            r_to_cnt      <= w_to_cnt;
            r_gap_cnt     <= w_gap_cnt;
            r_hs_grant    <= w_hs_grant;
            r_data_grant  <= w_data_grant;
            r_buf_rd      <= w_buf_rd;
            r_ack_prep    <= w_ack_prep;
            r_tx_ena      <= w_tx_ena;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err_timeout <= w_timeout;
            r_err_req     <= w_err_req;
            r_pid         <= w_pid;
            r_parallel_in <= w_parallel_in;
        end
    end

    // DATA_FETCH spans two cycles: the buf_rd cycle, then the cycle buf_data is valid.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (hs_req) begin
                    if (w_hs_legal) w_state_nxt = S_HS_WAIT;
                end else if (data_req && w_len_legal) begin
                    w_state_nxt = S_DATA_FETCH;
                end
            end
            S_HS_WAIT: begin
                if (ack_done) begin
                    w_state_nxt = S_GAP;
                end else if (w_to_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_DATA_FETCH: begin
                if (!r_buf_rd) w_state_nxt = S_DATA_RUN;
            end
            S_DATA_RUN: begin
                if (tx_load && (r_remaining != 7'd0)) begin
                    w_state_nxt = (r_remaining == 7'd1) ? S_DATA_WAIT : S_DATA_FETCH;
                end else if (w_to_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_DATA_WAIT: begin
                if (tx_complete) begin
                    w_state_nxt = S_GAP;
                end else if (w_to_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == LP_GAP_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_hs_grant    = 1'b0;
        w_data_grant  = 1'b0;
        w_buf_rd      = 1'b0;
        w_ack_prep    = 1'b0;
        w_done        = 1'b0;
        w_err_req     = 1'b0;
        w_tx_ena      = r_tx_ena;
        w_pid         = r_pid;
        w_parallel_in = r_parallel_in;
        w_remaining   = r_remaining;
        w_gap_cnt     = '0;
        w_to_cnt      = '0;
        w_busy        = (w_state_nxt != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (hs_req) begin
                    if (w_hs_legal) begin
                        w_hs_grant = 1'b1;
                        w_ack_prep = 1'b1;
                        w_pid      = hs_pid;
                    end else begin
                        w_err_req = 1'b1;
                    end
                end else if (data_req) begin
                    if (w_len_legal) begin
                        w_data_grant = 1'b1;
                        w_buf_rd     = 1'b1;
                        w_pid        = LP_PID_DATA;
                        w_remaining  = data_len;
                    end else begin
                        w_err_req = 1'b1;
                    end
                end
            end
            S_HS_WAIT:   w_done = ack_done;
            S_DATA_FETCH: begin
                if (!r_buf_rd) begin
                    w_parallel_in = buf_data;
                    w_tx_ena      = 1'b1;
                end
            end
            S_DATA_RUN: begin
                if (tx_load && (r_remaining != 7'd0)) begin
                    w_remaining = r_remaining - 7'd1;
                    if (r_remaining == 7'd1) w_tx_ena = 1'b0;
                    else                     w_buf_rd = 1'b1;
                end
            end
            S_DATA_WAIT: w_done = tx_complete;
            S_GAP:       w_gap_cnt = r_gap_cnt + 1'b1;
            default: ;
        endcase
        if (w_timeout) w_tx_ena = 1'b0;
        // Any state change (including the one every accepted tx_load causes) clears the counter.
        if ((w_state_nxt == r_state) &&
            ((r_state == S_HS_WAIT) || (r_state == S_DATA_RUN) || (r_state == S_DATA_WAIT))) begin
            w_to_cnt = r_to_cnt + 12'd1;
        end
    end

    assign hs_grant    = r_hs_grant;
    assign data_grant  = r_data_grant;
    assign buf_rd      = r_buf_rd;
    assign ack_prep    = r_ack_prep;
    assign tx_ena      = r_tx_ena;
    assign pid         = r_pid;
    assign parallel_in = r_parallel_in;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_err_timeout;
    assign err_req     = r_err_req;

endmodule
